// File: rtl/acq_pkg.sv
// Shared types and defaults for the acquisition correlator sequencer.
// Core instantiation and sequencer use the same size defaults.
package acq_pkg;

  localparam int unsigned CORE_SIZE_DEF = 256;
  localparam int unsigned BLK_W_DEF     = 16;
  localparam int unsigned TMO_W_DEF     = 10;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } acq_seq_state_t;

endpackage

// File: rtl/acq_core_seq_if.sv
// Control strobes between the sequencer and the correlator core.
// The sequencer is the slave side; the core returns valid.
interface core_interface;

  logic we;
  logic data_latch;
  logic we_adder;
  logic code_load;
  logic wr_buf;
  logic valid;

  modport slave (
    output we,
    output data_latch,
    output we_adder,
    output code_load,
    output wr_buf,
    input  valid
  );

  modport master (
    input  we,
    input  data_latch,
    input  we_adder,
    input  code_load,
    input  wr_buf,
    output valid
  );

endinterface

// File: rtl/acq_core_seq_tmo.sv
// Reloadable saturating timeout counter.
// tc_o is high once the counter has saturated at all-ones.
module acq_tmo_cnt #(
  parameter int unsigned W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic reload_i,
  output logic tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (reload_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/acq_core_seq.sv
// Sequencer for the acquisition correlator core: fills blocks,
// fires the adder, counts results, reports done or timeout.
module acq_core_seq
  import acq_pkg::*;
#(
  parameter int unsigned CORE_SIZE = CORE_SIZE_DEF,
  parameter int unsigned BLK_W     = BLK_W_DEF,
  parameter int unsigned TMO_W     = TMO_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [BLK_W-1:0] n_blocks,
  input  logic             sample_vld,
  core_interface.slave     core_if,
  output logic             busy,
  output logic [BLK_W-1:0] blk_latched,
  output logic [BLK_W-1:0] res_cnt,
  output logic             res_vld,
  output logic             done,
  output logic             tmo
);

  localparam int unsigned CW = $clog2(CORE_SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(CORE_SIZE - 1);

  acq_seq_state_t   state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] res_q, res_d;
  logic [BLK_W-1:0] nblk_q, nblk_d;
  logic             tmo_q, tmo_d;
  logic             wea_q;

  logic active;
  logic we;
  logic boundary;
  logic cnt_vld;
  logic start_acc;
  logic tmo_en;
  logic tmo_tc;
  logic tmo_fire;

  assign active    = (state_q == FILL) || (state_q == DRAIN);
  assign we        = (state_q == FILL) && sample_vld;
  assign boundary  = we && (cnt_q == CNT_LAST);
  assign start_acc = (state_q == IDLE) && start;
  // Results beyond the programmed count are not counted.
  assign cnt_vld   = active && core_if.valid && (res_q != nblk_q);
  assign tmo_en    = active && (blk_q != res_q);
  assign tmo_fire  = tmo_en && tmo_tc && !cnt_vld;

  acq_tmo_cnt #(
    .W (TMO_W)
  ) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .en_i     (tmo_en),
    .reload_i (cnt_vld || start_acc),
    .tc_o     (tmo_tc)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    res_d   = res_q;
    nblk_d  = nblk_q;
    tmo_d   = tmo_q;
    if (cnt_vld) res_d = res_q + BLK_W'(1);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          blk_d   = '0;
          res_d   = '0;
          tmo_d   = 1'b0;
          nblk_d  = n_blocks;
          state_d = (n_blocks == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (we) cnt_d = cnt_q + CW'(1);
        if (boundary) begin
          blk_d = blk_q + BLK_W'(1);
          if (blk_d == nblk_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (res_d == nblk_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (tmo_fire) begin
      tmo_d   = 1'b1;
      state_d = IDLE;
    end
    if (abort && state_q != IDLE) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      blk_q   <= '0;
      res_q   <= '0;
      nblk_q  <= '0;
      tmo_q   <= 1'b0;
      wea_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      res_q   <= res_d;
      nblk_q  <= nblk_d;
      tmo_q   <= tmo_d;
      wea_q   <= boundary;
    end
  end

  assign core_if.we         = we;
  assign core_if.data_latch = boundary;
  assign core_if.code_load  = boundary;
  assign core_if.wr_buf     = boundary && (blk_q == '0);
  assign core_if.we_adder   = wea_q;

  assign busy        = (state_q != IDLE);
  assign blk_latched = blk_q;
  assign res_cnt     = res_q;
  assign res_vld     = active && core_if.valid;
  assign done        = (state_q == DONE);
  assign tmo         = tmo_q;

endmodule

// File: tb/tb_acq_core_seq.sv
// Scoreboard bench for acq_core_seq with a behavioural core
// returning valid 4 cycles after we_adder.
module tb_acq_core_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] n_blocks;
  logic        sample_vld;
  logic        busy;
  logic [15:0] blk_latched;
  logic [15:0] res_cnt;
  logic        res_vld;
  logic        done;
  logic        tmo;

  core_interface cif ();

  acq_core_seq #(
    .CORE_SIZE (8),
    .BLK_W     (16),
    .TMO_W     (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .n_blocks    (n_blocks),
    .sample_vld  (sample_vld),
    .core_if     (cif),
    .busy        (busy),
    .blk_latched (blk_latched),
    .res_cnt     (res_cnt),
    .res_vld     (res_vld),
    .done        (done),
    .tmo         (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // core model: drop results while defer, inject one on rel
  logic [3:0] pipe = '0;
  logic       defer;
  logic       rel;
  always @(posedge clk) pipe <= {pipe[2:0], cif.we_adder === 1'b1};
  assign cif.valid = (pipe[3] & ~defer) | rel;

  typedef struct { int cyc; int wr; } lat_t;
  typedef struct { int cyc; int res; int blk; } dn_t;
  lat_t lat_q[$];
  dn_t  dn_q[$];
  int   res_q[$];
  lat_t le;
  dn_t  de;
  int   re;
  logic dl_prev = 1'b0;

  int checks = 0;
  int errors = 0;
  int c0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d",
               nm, cyc, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (cif.data_latch === 1'b1) begin
      if (lat_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_latch cycle=%0d", cyc);
      end else begin
        le = lat_q.pop_front();
        chk("latch_cyc", cyc, le.cyc);
        chk("wr_buf", int'(cif.wr_buf), le.wr);
        chk("code_load", int'(cif.code_load), 1);
      end
    end
    if (cif.we_adder === 1'b1 || dl_prev)
      chk("we_adder", int'(cif.we_adder), int'(dl_prev));
    dl_prev <= (cif.data_latch === 1'b1);
    if (busy === 1'b1 && !sample_vld)
      chk("we_gated", int'(cif.we), 0);
    if (res_vld === 1'b1) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result cycle=%0d", cyc);
      end else begin
        re = res_q.pop_front();
        chk("res_cnt_pre", int'(res_cnt), re);
      end
    end
    if (done === 1'b1) begin
      if (dn_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done cycle=%0d", cyc);
      end else begin
        de = dn_q.pop_front();
        chk("done_cyc", cyc, de.cyc);
        chk("done_res", int'(res_cnt), de.res);
        chk("done_blk", int'(blk_latched), de.blk);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start    = 1'b1;
    n_blocks = 16'(n);
    c0       = cyc;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int k = 0;
    while (busy && k < bound) begin
      tick();
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle cycle=%0d still busy", cyc);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tmo"}, int'(tmo), 0);
    chk({tag, "_res_vld"}, int'(res_vld), 0);
    chk({tag, "_blk"}, int'(blk_latched), 0);
    chk({tag, "_res"}, int'(res_cnt), 0);
    chk({tag, "_we"}, int'(cif.we), 0);
    chk({tag, "_dl"}, int'(cif.data_latch), 0);
    chk({tag, "_wea"}, int'(cif.we_adder), 0);
    chk({tag, "_cl"}, int'(cif.code_load), 0);
    chk({tag, "_wrb"}, int'(cif.wr_buf), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    n_blocks = '0; sample_vld = 1'b0;
    defer = 1'b0; rel = 1'b0;
    repeat (3) tick();
    chk_reset_vals("rst");
    reset = 1'b0;
    tick();

    // continuous samples, three blocks
    do_start(3);
    sample_vld = 1'b1;
    lat_q.push_back('{c0 + 8, 1});
    lat_q.push_back('{c0 + 16, 0});
    lat_q.push_back('{c0 + 24, 0});
    res_q.push_back(0);
    res_q.push_back(1);
    res_q.push_back(2);
    dn_q.push_back('{c0 + 30, 3, 3});
    repeat (24) tick();
    sample_vld = 1'b0;
    wait_idle(100);
    chk("t1_blk_hold", int'(blk_latched), 3);
    chk("t1_res_hold", int'(res_cnt), 3);
    repeat (3) tick();

    // alternating samples, one block
    do_start(1);
    lat_q.push_back('{c0 + 15, 1});
    res_q.push_back(0);
    dn_q.push_back('{c0 + 21, 1, 1});
    for (int i = 0; i < 16; i++) begin
      sample_vld = (i % 2 == 0);
      tick();
    end
    sample_vld = 1'b0;
    wait_idle(100);
    repeat (3) tick();

    // zero blocks: immediate done, no strobes
    sample_vld = 1'b1;
    do_start(0);
    dn_q.push_back('{c0 + 1, 0, 0});
    for (int i = 0; i < 4; i++) begin
      chk("n0_we", int'(cif.we), 0);
      tick();
    end
    sample_vld = 1'b0;
    chk("n0_busy", int'(busy), 0);
    repeat (2) tick();

    // second result withheld: timeout
    do_start(2);
    sample_vld = 1'b1;
    lat_q.push_back('{c0 + 8, 1});
    lat_q.push_back('{c0 + 16, 0});
    res_q.push_back(0);
    for (int i = 1; i <= 16; i++) begin
      if (i == 14) defer = 1'b1;
      tick();
    end
    sample_vld = 1'b0;
    for (int k = 0; k < 120 && !tmo; k++) tick();
    t = cyc;
    checks++;
    if (t < c0 + 80 || t > c0 + 82) begin
      errors++;
      $display("FAIL tmo_cycle actual=%0d expected=%0d..%0d",
               t - c0, 80, 82);
    end
    chk("tmo_flag", int'(tmo), 1);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_res", int'(res_cnt), 1);
    chk("tmo_blk", int'(blk_latched), 2);
    repeat (8) tick();
    defer = 1'b0;
    chk("tmo_sticky", int'(tmo), 1);

    // abort during fill, then a clean rerun
    do_start(1);
    chk("start_clr_tmo", int'(tmo), 0);
    sample_vld = 1'b1;
    repeat (5) tick();
    sample_vld = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_blk", int'(blk_latched), 0);
    tick();
    do_start(1);
    sample_vld = 1'b1;
    lat_q.push_back('{c0 + 8, 1});
    res_q.push_back(0);
    dn_q.push_back('{c0 + 14, 1, 1});
    repeat (8) tick();
    sample_vld = 1'b0;
    wait_idle(100);
    repeat (2) tick();

    // reset while draining
    do_start(2);
    sample_vld = 1'b1;
    lat_q.push_back('{c0 + 8, 1});
    lat_q.push_back('{c0 + 16, 0});
    res_q.push_back(0);
    repeat (16) tick();
    sample_vld = 1'b0;
    tick();
    chk("drain_busy", int'(busy), 1);
    reset = 1'b1;
    tick();
    chk_reset_vals("mid");
    reset = 1'b0;
    tick();
    tick();
    chk("post_rst_res_vld", int'(res_vld), 0);
    chk("post_rst_res", int'(res_cnt), 0);
    repeat (4) tick();

    // result coincides with boundary; start while busy
    defer = 1'b1;
    do_start(2);
    sample_vld = 1'b1;
    lat_q.push_back('{c0 + 8, 1});
    lat_q.push_back('{c0 + 16, 0});
    res_q.push_back(0);
    res_q.push_back(1);
    dn_q.push_back('{c0 + 22, 2, 2});
    for (int i = 1; i <= 16; i++) begin
      start    = (i == 3);
      n_blocks = (i == 3) ? 16'd5 : 16'd2;
      rel      = (i == 16);
      tick();
    end
    start = 1'b0; rel = 1'b0; defer = 1'b0;
    sample_vld = 1'b0;
    chk("coin_blk", int'(blk_latched), 2);
    chk("coin_res", int'(res_cnt), 1);
    chk("coin_busy", int'(busy), 1);
    wait_idle(100);
    chk("coin_res_end", int'(res_cnt), 2);
    repeat (3) tick();

    chk("lat_q_empty", lat_q.size(), 0);
    chk("res_q_empty", res_q.size(), 0);
    chk("dn_q_empty", dn_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
